// File: rtl/mmu_controller_nxn.sv
// N x N matrix-multiply controller: buffers byte-serial A/B loads, feeds them skewed
// into an output-stationary systolic PE grid, then offers random-access readback of C.
//
// state  | meaning
// IDLE   | accepting A/B slot loads; leaves once every slot of both matrices is loaded
// FEED   | skewed operands streamed into the grid for 3N-1 cycles
// OUTPUT | accumulators frozen; readback until release_req
module mmu_controller_nxn #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int IW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          load_sel_ab,
  input  logic [IW-1:0] load_index,
  input  logic [DW-1:0] in_data,
  input  logic          signed_mode,
  input  logic          acc_keep,
  input  logic          output_en,
  input  logic [IW-1:0] output_sel,
  input  logic [1:0]    out_part,
  input  logic          out_sat,
  input  logic          release_req,   // "release" is a reserved word
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, FEED, OUTPUT} state_t;

  localparam int NN = N*N;
  localparam int CW = $clog2(3*N);
  localparam int EW = (4*DW > AW) ? 4*DW : AW;
  localparam logic [CW-1:0] LAST_T = CW'(3*N-2);
  localparam logic [AW-1:0] UMAX = AW'((64'd1 << DW) - 64'd1);
  localparam logic [AW-1:0] SMAX = AW'((64'd1 << (DW-1)) - 64'd1);
  localparam logic [AW-1:0] SMIN = ~SMAX;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [NN-1:0] a_loaded, b_loaded;
  logic          signed_lat;
  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];

  logic start, load_ok;

  assign start   = (state == IDLE) && (&a_loaded) && (&b_loaded);
  assign load_ok = (state == IDLE) && !start && load_en && (32'(load_index) < NN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_loaded   <= '0;
      b_loaded   <= '0;
      signed_lat <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      for (int k = 0; k < NN; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      if (load_ok) begin
        if (load_sel_ab) begin
          b_mem[load_index]    <= in_data;
          b_loaded[load_index] <= 1'b1;
        end else begin
          a_mem[load_index]    <= in_data;
          a_loaded[load_index] <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state      <= FEED;
            cnt        <= '0;
            signed_lat <= signed_mode;
            done       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        FEED: begin
          if (cnt == LAST_T) begin
            state    <= OUTPUT;
            a_loaded <= '0;
            b_loaded <= '0;
            done     <= 1'b1;
            busy     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (release_req) begin
            state <= IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Skewed edge inputs: row i carries A[i][t-i], column j carries B[t-j][j].
  logic [DW-1:0] row_in [N];
  logic [DW-1:0] col_in [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      row_in[i] = '0;
      col_in[i] = '0;
      if (state == FEED) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt) == i + k) begin
            row_in[i] = a_mem[i*N + k];
            col_in[i] = b_mem[k*N + i];
          end
        end
      end
    end
  end

  logic [DW-1:0] a_reg [N][N];
  logic [DW-1:0] b_reg [N][N];
  logic [DW-1:0] pe_a  [N][N];
  logic [DW-1:0] pe_b  [N][N];
  logic [AW-1:0] acc   [NN];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pe_a[i][0] = row_in[i];
      pe_b[0][i] = col_in[i];
      for (int j = 1; j < N; j++) begin
        pe_a[i][j] = a_reg[i][j-1];
        pe_b[j][i] = b_reg[j-1][i];
      end
    end
  end

  function automatic logic [AW-1:0] ext_op(input logic [DW-1:0] v, input logic s);
    ext_op = {{(AW-DW){s & v[DW-1]}}, v};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j]  <= '0;
          b_reg[i][j]  <= '0;
          acc[i*N + j] <= '0;
        end
      end
    end else if (start) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
          if (!acc_keep) acc[i*N + j] <= '0;
        end
      end
    end else if (state == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j]  <= pe_a[i][j];
          b_reg[i][j]  <= pe_b[i][j];
          acc[i*N + j] <= acc[i*N + j] +
                          ext_op(pe_a[i][j], signed_lat) * ext_op(pe_b[i][j], signed_lat);
        end
      end
    end
  end

  logic [AW-1:0] c_sel;
  logic [EW-1:0] c_ext;
  logic [DW-1:0] slice, sat;

  always_comb begin
    c_sel = '0;
    if (32'(output_sel) < NN) c_sel = acc[output_sel];
    if (signed_lat) c_ext = EW'($signed(c_sel));
    else            c_ext = EW'(c_sel);
    slice = c_ext[out_part*DW +: DW];
    if (signed_lat) begin
      if ($signed(c_sel) > $signed(SMAX))      sat = SMAX[DW-1:0];
      else if ($signed(c_sel) < $signed(SMIN)) sat = SMIN[DW-1:0];
      else                                     sat = c_sel[DW-1:0];
    end else begin
      sat = (c_sel > UMAX) ? UMAX[DW-1:0] : c_sel[DW-1:0];
    end
    out_data = '0;
    if (output_en && !rst) out_data = out_sat ? sat : slice;
  end

endmodule

// File: tb/tb_mmu_controller_nxn.sv
// Directed bench for mmu_controller_nxn: N=2 instance for arithmetic/modes/reset,
// N=3 instance for identity multiply and out-of-range loads.
module tb_mmu_controller_nxn;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       load_en, load_sel_ab, signed_mode, acc_keep, output_en, out_sat, release_req;
  logic [1:0] load_index, output_sel, out_part;
  logic [7:0] in_data, out_data;
  logic       done, busy;

  logic       load_en3, load_sel3, output_en3, release3, zero1;
  logic [1:0] zero2;
  logic [3:0] load_index3, output_sel3;
  logic [7:0] in_data3, out_data3;
  logic       done3, busy3;

  mmu_controller_nxn #(.N(2), .DW(8), .AW(20)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel_ab(load_sel_ab),
    .load_index(load_index), .in_data(in_data), .signed_mode(signed_mode),
    .acc_keep(acc_keep), .output_en(output_en), .output_sel(output_sel),
    .out_part(out_part), .out_sat(out_sat), .release_req(release_req),
    .out_data(out_data), .done(done), .busy(busy)
  );

  mmu_controller_nxn #(.N(3), .DW(8), .AW(20)) dut3 (
    .clk(clk), .rst(rst), .load_en(load_en3), .load_sel_ab(load_sel3),
    .load_index(load_index3), .in_data(in_data3), .signed_mode(zero1),
    .acc_keep(zero1), .output_en(output_en3), .output_sel(output_sel3),
    .out_part(zero2), .out_sat(zero1), .release_req(release3),
    .out_data(out_data3), .done(done3), .busy(busy3)
  );

  int n_chk = 0;
  int n_pass = 0;
  int lat;
  logic [7:0] am [4];
  logic [7:0] bm [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic load2(input logic sm, input logic ak);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_en = 1'b1; load_sel_ab = 1'b0; load_index = 2'(k); in_data = am[k];
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_en = 1'b1; load_sel_ab = 1'b1; load_index = 2'(k); in_data = bm[k];
    end
    signed_mode = sm;
    acc_keep    = ak;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic wait_done2(output int l);
    l = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done) begin
        l = e;
        break;
      end
    end
  endtask

  task automatic run2(input logic sm, input logic ak, output int l);
    load2(sm, ak);
    wait_done2(l);
  endtask

  task automatic chk_rd(input string tag, input int sel, input int part, input logic sat,
                        input logic [7:0] exp);
    output_en = 1'b1; output_sel = 2'(sel); out_part = 2'(part); out_sat = sat;
    #1;
    chk(tag, 32'(out_data), 32'(exp));
  endtask

  task automatic rel2(input string tag, input int sel, input logic [7:0] exp);
    @(negedge clk);
    release_req = 1'b1; output_en = 1'b1; output_sel = 2'(sel); out_part = 2'd0; out_sat = 1'b0;
    #1;
    chk(tag, 32'(out_data), 32'(exp));
    @(posedge clk); #1;
    release_req = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    load_en = 0; load_sel_ab = 0; signed_mode = 0; acc_keep = 0; output_en = 0;
    out_sat = 0; release_req = 0; load_index = 0; output_sel = 0; out_part = 0; in_data = 0;
    load_en3 = 0; load_sel3 = 0; output_en3 = 0; release3 = 0; zero1 = 0; zero2 = 0;
    load_index3 = 0; output_sel3 = 0; in_data3 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    output_en = 1'b1; output_sel = 2'd3;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out_data), 32'd0);
    @(negedge clk) rst = 1'b0;

    // unsigned 2x2
    am = '{8'd1, 8'd2, 8'd3, 8'd4};
    bm = '{8'd5, 8'd6, 8'd7, 8'd8};
    run2(1'b0, 1'b0, lat);
    chk("u_latency", 32'(lat), 32'd6);
    chk("u_busy", 32'(busy), 32'd1);
    chk_rd("u_c00", 0, 0, 1'b0, 8'd19);
    chk_rd("u_c01", 1, 0, 1'b0, 8'd22);
    chk_rd("u_c10", 2, 0, 1'b0, 8'd43);
    chk_rd("u_c11", 3, 0, 1'b0, 8'h32);
    chk_rd("u_c11_p1", 3, 1, 1'b0, 8'd0);
    chk_rd("u_c11_sat", 3, 0, 1'b1, 8'd50);
    output_en = 1'b0; #1;
    chk("u_oe0", 32'(out_data), 32'd0);
    rel2("u_rel", 0, 8'd19);
    chk("u_done_after_rel", 32'(done), 32'd0);

    // accumulate on top of the previous result, then restart fresh
    run2(1'b0, 1'b1, lat);
    chk("acc_latency", 32'(lat), 32'd6);
    chk_rd("acc_c00", 0, 0, 1'b0, 8'd38);
    chk_rd("acc_c11", 3, 0, 1'b0, 8'd100);
    rel2("acc_rel", 3, 8'd100);
    run2(1'b0, 1'b0, lat);
    chk_rd("noacc_c00", 0, 0, 1'b0, 8'd19);
    rel2("noacc_rel", 0, 8'd19);

    // signed 2x2: C = [9,10;-13,-14]
    am = '{8'hFF, 8'h02, 8'h03, 8'hFC};
    run2(1'b1, 1'b0, lat);
    chk("s_latency", 32'(lat), 32'd6);
    chk_rd("s_c00", 0, 0, 1'b0, 8'd9);
    chk_rd("s_c01", 1, 0, 1'b0, 8'd10);
    chk_rd("s_c10_p0", 2, 0, 1'b0, 8'hF3);
    chk_rd("s_c10_p2", 2, 2, 1'b0, 8'hFF);
    chk_rd("s_c10_sat", 2, 0, 1'b1, 8'hF3);
    chk_rd("s_c11", 3, 0, 1'b0, 8'hF2);
    rel2("s_rel", 2, 8'hF3);

    // unsigned saturation: C = 0x1FC02
    am = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bm = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run2(1'b0, 1'b0, lat);
    chk_rd("us_p0", 1, 0, 1'b0, 8'h02);
    chk_rd("us_p1", 1, 1, 1'b0, 8'hFC);
    chk_rd("us_p2", 1, 2, 1'b0, 8'h01);
    chk_rd("us_p3", 1, 3, 1'b0, 8'h00);
    chk_rd("us_sat", 1, 0, 1'b1, 8'hFF);
    rel2("us_rel", 1, 8'h02);

    // signed saturation: C = 32768
    am = '{8'h80, 8'h80, 8'h80, 8'h80};
    bm = '{8'h80, 8'h80, 8'h80, 8'h80};
    run2(1'b1, 1'b0, lat);
    chk_rd("ss_p0", 2, 0, 1'b0, 8'h00);
    chk_rd("ss_p1", 2, 1, 1'b0, 8'h80);
    chk_rd("ss_p3", 2, 3, 1'b0, 8'h00);
    chk_rd("ss_sat", 2, 0, 1'b1, 8'h7F);
    rel2("ss_rel", 2, 8'h00);

    // reset mid-FEED, then a clean run
    am = '{8'd1, 8'd2, 8'd3, 8'd4};
    bm = '{8'd5, 8'd6, 8'd7, 8'd8};
    load2(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    output_en = 1'b1; output_sel = 2'd3; out_part = 2'd0; out_sat = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out", 32'(out_data), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 4; k++) chk_rd("mid_rst_zero", k, 1'b0 ? 1 : 0, 1'b0, 8'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    run2(1'b0, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd6);
    chk_rd("post_rst_c11", 3, 0, 1'b0, 8'h32);
    rel2("post_rst_rel", 3, 8'h32);

    // N=3: identity x (1..9), with stray out-of-range loads first
    for (int k = 9; k < 16; k++) begin
      @(negedge clk);
      load_en3 = 1'b1; load_sel3 = k[0]; load_index3 = 4'(k); in_data3 = 8'h55;
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      load_en3 = 1'b1; load_sel3 = 1'b0; load_index3 = 4'(k);
      in_data3 = (k == 0 || k == 4 || k == 8) ? 8'd1 : 8'd0;
    end
    @(negedge clk);
    load_en3 = 1'b0;
    chk("n3_idle_after_a", 32'(busy3), 32'd0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      load_en3 = 1'b1; load_sel3 = 1'b1; load_index3 = 4'(k); in_data3 = 8'(k + 1);
    end
    @(posedge clk); #1;
    load_en3 = 1'b0;
    lat = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done3) begin
        lat = e;
        break;
      end
    end
    chk("n3_latency", 32'(lat), 32'd9);
    output_en3 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      output_sel3 = 4'(k);
      #1;
      chk("n3_c", 32'(out_data3), 32'(k + 1));
    end
    output_sel3 = 4'd9;
    #1;
    chk("n3_oob_read", 32'(out_data3), 32'd0);
    @(negedge clk) release3 = 1'b1;
    @(posedge clk); #1;
    release3 = 1'b0;
    chk("n3_rel_busy", 32'(busy3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmu_controller_nxn.md
# mmu_controller_nxn

Parametrised N×N matrix-multiply controller with an embedded output-stationary systolic PE grid. Buffers byte-serial loads of A and B (row-major), feeds them skewed into the grid, then exposes C = A·B, or C += A·B, for random-access DW-bit readback. Supports signed/unsigned operands, accumulate-across-operations, and saturated or sliced readback. Host-side successor of the fixed 2×2 controller; sits between the I/O shim and nothing else.

## Interface
- N, 2, matrix dimension (2..4); IW = $clog2(N*N)
- DW, 8, operand and out_data width
- AW, 20, accumulator width (AW ≥ 2*DW; results wrap modulo 2^AW)
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, asynchronous and active-high
- load_en  in  1  write in_data to A/B slot (IDLE only)
- load_sel_ab  in  1  0 = A, 1 = B
- load_index  in  IW  row-major slot i*N+j; values ≥ N*N ignored
- in_data  in  DW  operand byte
- signed_mode  in  1  operands two's complement; sampled on IDLE→FEED edge
- acc_keep  in  1  keep accumulators (C += A·B); sampled on IDLE→FEED edge
- output_en  in  1  enable readback
- output_sel  in  IW  C element i*N+j
- out_part  in  2  DW-bit slice p of C: bits [p*DW +: DW], sign-/zero-extended past AW
- out_sat  in  1  1 = saturate C to DW bits instead of slicing
- release  in  1  finish readback, return to IDLE
- out_data  out  DW  readback value
- done  out  1  state == OUTPUT
- busy  out  1  state != IDLE

## Operation
- States: IDLE, FEED, OUTPUT. Reset → IDLE; A, B, masks, accumulators, counters, latched modes all 0.
- IDLE: load_en writes A or B slot and sets its bit in a_loaded/b_loaded (N*N bits each). Reloading a slot overwrites. When both masks are all-ones, next edge → FEED. Loads outside IDLE ignored.
- IDLE→FEED edge: latch signed_mode, acc_keep; cycle counter ← 0; clear all accumulators unless acc_keep=1.
- FEED, cycle t = 0..3N-2: row input i = A[i][t-i] and column input j = B[t-j][j] when 0 ≤ t-i (resp. t-j) < N, else 0.
- PE(i,j): registers a rightward and b downward (1-cycle hop); acc += a*b each cycle. Product is 2*DW bits, signed or unsigned per latched mode, extended to AW, summed modulo 2^AW.
- After cycle 3N-2 → OUTPUT. Masks cleared on this edge.
- OUTPUT: accumulators frozen. release=1 → IDLE next edge. Accumulators keep values until the next FEED entry.
- Readback is combinational. output_en=0 → out_data=0. output_en=1 → slice or saturated value of C[output_sel]. Readable in any state; 0 while output_en=0. Indices ≥ N*N read 0.
- Saturation: unsigned clamps to [0, 2^DW-1]; signed clamps to [-2^(DW-1), 2^(DW-1)-1].

## Timing
- done and busy are registered state decodes; both 0 out of reset.
- done rises exactly 3N edges after the edge capturing the final load (N=2: 6, N=3: 9).
- release in OUTPUT with output_en in the same cycle returns valid data that cycle, then IDLE.
- release outside OUTPUT is ignored. load_en in the same cycle as the IDLE→FEED edge is ignored.
- rst asserted mid-FEED or mid-OUTPUT → immediately IDLE with all storage zeroed. out_data = 0 while rst is high.
- A/B contents survive release. Only the masks are cleared, so every slot must be rewritten.

## Test plan
- N=2 unsigned: A=[1,2;3,4], B=[5,6;7,8] → C=[19,22;43,50]. done 6 edges after last load. Part0 of C11 = 0x32.
- N=2 signed: A=[0xFF,0x02;0x03,0xFC], B=[5,6;7,8] → C=[9,10;-13,-14]. C10 part0 = 0xF3, part2 = 0xFF, sat = 0xF3.
- N=2 saturation:
  - unsigned, all A=B=0xFF → C=0x1FC02; parts 0x02/0xFC/0x01; sat 0xFF.
  - signed, all 0x80 → C=32768; sat 0x7F.
- Accumulate: rerun the unsigned case with acc_keep=1 → C00=38, C11=100. Next run with acc_keep=0 → C00=19.
- N=3: A=identity, B=1..9 → C=B. done 9 edges after last load. Out-of-range load_index 9..15 ignored.
- rst pulsed mid-FEED → busy=0, out_data reads 0 for all elements. A subsequent full load completes normally.
